clk_freq_monitor: RTL and testbench

Measures the frequency of a PLL-derived clock and reports whether the PLL output is present and on frequency. The block is clocked by the 27 MHz board clock, i.e. the same reference that feeds the PLL. The measured signal is a divided-down PLL output (e.g. 100.29 MHz / 8 = 12.536 MHz). It arrives as an asynchronous data input, is synchronised, and its rising edges are counted over a fixed gate window. A lock qualifier asserts `locked` after consecutive in-tolerance windows; downstream logic (keypad scanner, display) uses it as a go/no-go.

---
 rtl/clk_freq_monitor.sv | 150 +++++++++++++++
 tb/tb_clk_freq_monitor.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_freq_monitor.sv
// Counts synchronised rising edges of meas_in over a GATE_CYCLES window and qualifies lock.
// Results land one clk after the terminal gate cycle; no backpressure, count_valid is a bare pulse.
module clk_freq_monitor #(
  parameter int GATE_CYCLES  = 27000,
  parameter int EXPECT_COUNT = 12536,
  parameter int TOLERANCE    = 64,
  parameter int LOCK_WINDOWS = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             meas_in,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  output logic             in_range,
  output logic             locked
);

  localparam int GATE_W = $clog2(GATE_CYCLES);
  localparam int GOOD_W = $clog2(LOCK_WINDOWS + 1);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W:0]    EXP_C     = (CNT_W+1)'(EXPECT_COUNT);
  localparam logic [CNT_W:0]    TOL_C     = (CNT_W+1)'(TOLERANCE);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_WINDOWS);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              hist_q, hist_d;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0]  count_out_q, count_out_d;
  logic              count_valid_q, count_valid_d;
  logic              in_range_q, in_range_d;
  state_t            state_q, state_d;
  logic [GOOD_W-1:0] good_q, good_d;

  logic              edge_det;
  logic              terminal;
  logic [CNT_W:0]    sum;
  logic [CNT_W-1:0]  result;
  logic [CNT_W:0]    res_ext;
  logic [CNT_W:0]    diff;
  logic              win_ok;
  logic [GOOD_W-1:0] good_inc;

  always_comb begin
    sync1_d       = meas_in;
    sync2_d       = sync1_q;
    hist_d        = sync2_q;
    gate_d        = gate_q;
    edge_cnt_d    = edge_cnt_q;
    count_out_d   = count_out_q;
    count_valid_d = 1'b0;
    in_range_d    = in_range_q;
    state_d       = state_q;
    good_d        = good_q;

    edge_det = sync2_q & ~hist_q;
    terminal = enable && (gate_q == GATE_LAST);
    // One extra bit catches the carry so the running count saturates instead of wrapping.
    sum      = {1'b0, edge_cnt_q} + {{CNT_W{1'b0}}, edge_det};
    result   = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
    res_ext  = {1'b0, result};
    diff     = (res_ext >= EXP_C) ? (res_ext - EXP_C) : (EXP_C - res_ext);
    win_ok   = (diff <= TOL_C);
    good_inc = good_q + 1'b1;

    if (!enable) begin
      gate_d     = '0;
      edge_cnt_d = '0;
      in_range_d = 1'b0;
      state_d    = UNLOCKED;
      good_d     = '0;
    end else if (terminal) begin
      gate_d        = '0;
      edge_cnt_d    = '0;
      count_out_d   = result;
      count_valid_d = 1'b1;
      in_range_d    = win_ok;
      case (state_q)
        UNLOCKED: begin
          if (win_ok) begin
            good_d  = GOOD_W'(1);
            state_d = (LOCK_WINDOWS == 1) ? LOCKED : ACQUIRE;
          end else begin
            good_d  = '0;
          end
        end
        ACQUIRE: begin
          if (win_ok) begin
            good_d = good_inc;
            if (good_inc == GOOD_LAST) state_d = LOCKED;
          end else begin
            state_d = UNLOCKED;
            good_d  = '0;
          end
        end
        LOCKED: begin
          if (!win_ok) begin
            state_d = UNLOCKED;
            good_d  = '0;
          end
        end
        default: begin
          state_d = UNLOCKED;
          good_d  = '0;
        end
      endcase
    end else begin
      gate_d     = gate_q + 1'b1;
      edge_cnt_d = result;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      hist_q        <= 1'b0;
      gate_q        <= '0;
      edge_cnt_q    <= '0;
      count_out_q   <= '0;
      count_valid_q <= 1'b0;
      in_range_q    <= 1'b0;
      state_q       <= UNLOCKED;
      good_q        <= '0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      hist_q        <= hist_d;
      gate_q        <= gate_d;
      edge_cnt_q    <= edge_cnt_d;
      count_out_q   <= count_out_d;
      count_valid_q <= count_valid_d;
      in_range_q    <= in_range_d;
      state_q       <= state_d;
      good_q        <= good_d;
    end
  end

  assign count_out   = count_out_q;
  assign count_valid = count_valid_q;
  assign in_range    = in_range_q;
  assign locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Directed windows of known meas_in patterns, each window aligned to the DUT gate so edge counts are exact.
module tb_clk_freq_monitor;

  localparam int PER = 10;

  logic       clk;
  logic       rst;
  logic       enable, enable2;
  logic       meas_in, meas2;
  logic [7:0] count_out, count_out2;
  logic       count_valid, count_valid2;
  logic       in_range, in_range2;
  logic       locked, locked2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int     lo;
    int     hi;
    logic   ir;
    logic   lk;
    longint t;
  } exp_t;

  exp_t q[$];
  exp_t q2[$];

  clk_freq_monitor #(.GATE_CYCLES(100), .EXPECT_COUNT(25), .TOLERANCE(1),
                     .LOCK_WINDOWS(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .meas_in(meas_in),
    .count_out(count_out), .count_valid(count_valid),
    .in_range(in_range), .locked(locked));

  clk_freq_monitor #(.GATE_CYCLES(1000), .EXPECT_COUNT(25), .TOLERANCE(1),
                     .LOCK_WINDOWS(4), .CNT_W(8)) dut_sat (
    .clk(clk), .rst(rst), .enable(enable2), .meas_in(meas2),
    .count_out(count_out2), .count_valid(count_valid2),
    .in_range(in_range2), .locked(locked2));

  initial begin
    clk = 1'b0;
    forever #(PER/2) clk = ~clk;
  end

  // mode 0: stuck low, 1: stuck high, N>=2: period N clk with the first N/2 cycles high
  function automatic logic pat(input int mode, input int p);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return ((p % mode) < (mode / 2));
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_result(input string tag, input exp_t e, input int cnt,
                            input logic ir, input logic lk);
    checks++;
    if (cnt < e.lo || cnt > e.hi) begin
      errors++;
      $display("FAIL %s count actual=%0d required=%0d..%0d at t=%0t", tag, cnt, e.lo, e.hi, $time);
    end
    chk({tag, " in_range"}, ir, e.ir);
    chk({tag, " locked"}, lk, e.lk);
    chk({tag, " valid_time"}, longint'($time), e.t);
  endtask

  // start: 0 continue running, 1 raise enable, 2 release rst at the window's first cycle
  task automatic run_window(input int mode, input int start, input int lo, input int hi,
                            input logic ir, input logic lk);
    exp_t e;
    for (int p = 0; p < 100; p++) begin
      @(negedge clk);
      if (p == 0) begin
        if (start == 1) enable = 1'b1;
        if (start == 2) rst = 1'b0;
        e.lo = lo; e.hi = hi; e.ir = ir; e.lk = lk;
        e.t  = longint'($time) + 100 * PER;
        q.push_back(e);
      end
      meas_in = pat(mode, p);
    end
  endtask

  always @(negedge clk) begin
    if (count_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual=1 required=0 at t=%0t", $time);
      end else begin
        cmp_result("win", q.pop_front(), int'(count_out), in_range, locked);
      end
    end
  end

  always @(negedge clk) begin
    if (count_valid2) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid_sat actual=1 required=0 at t=%0t", $time);
      end else begin
        cmp_result("sat", q2.pop_front(), int'(count_out2), in_range2, locked2);
      end
    end
  end

  initial begin
    exp_t e2;
    rst = 1'b1; enable = 1'b0; enable2 = 1'b0; meas_in = 1'b0; meas2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst count_out", count_out, 0);
    chk("rst count_valid", count_valid, 0);
    chk("rst in_range", in_range, 0);
    chk("rst locked", locked, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 1: period 4 locks on the 4th in-range window
    run_window(4, 1, 24, 25, 1, 0);
    run_window(4, 0, 25, 25, 1, 0);
    run_window(4, 0, 25, 25, 1, 0);
    run_window(4, 0, 25, 25, 1, 1);
    run_window(4, 0, 25, 25, 1, 1);

    // 2: period 5 breaks lock, four windows to relock
    run_window(5, 0, 20, 20, 0, 0);
    run_window(4, 0, 25, 25, 1, 0);
    run_window(4, 0, 25, 25, 1, 0);
    run_window(4, 0, 25, 25, 1, 0);
    run_window(4, 0, 25, 25, 1, 1);

    // 3: stuck low, relock, stuck high (one rise at entry, then none)
    run_window(0, 0, 0, 0, 0, 0);
    run_window(4, 0, 25, 25, 1, 0);
    run_window(4, 0, 25, 25, 1, 0);
    run_window(4, 0, 25, 25, 1, 0);
    run_window(4, 0, 25, 25, 1, 1);
    run_window(1, 0, 1, 1, 0, 0);
    run_window(1, 0, 0, 0, 0, 0);
    run_window(4, 0, 24, 24, 1, 0);
    run_window(4, 0, 25, 25, 1, 0);
    run_window(4, 0, 25, 25, 1, 0);
    run_window(4, 0, 25, 25, 1, 1);

    // 4: bad window while acquiring with three good windows
    run_window(5, 0, 20, 20, 0, 0);
    run_window(4, 0, 25, 25, 1, 0);
    run_window(4, 0, 25, 25, 1, 0);
    run_window(4, 0, 25, 25, 1, 0);
    run_window(5, 0, 20, 20, 0, 0);
    run_window(4, 0, 25, 25, 1, 0);
    run_window(4, 0, 25, 25, 1, 0);
    run_window(4, 0, 25, 25, 1, 0);
    run_window(4, 0, 25, 25, 1, 1);

    // 5: enable dropped at gate 50 while locked
    for (int p = 0; p <= 50; p++) begin
      @(negedge clk);
      if (p == 50) begin
        enable  = 1'b0;
        meas_in = 1'b0;
      end else begin
        meas_in = pat(4, p);
      end
    end
    @(negedge clk);
    chk("dis locked", locked, 0);
    chk("dis in_range", in_range, 0);
    chk("dis count_out", count_out, 25);
    chk("dis count_valid", count_valid, 0);
    repeat (20) @(negedge clk);
    run_window(4, 1, 25, 25, 1, 0);

    // 6a: async reset mid-window, then first window from release
    for (int p = 0; p < 30; p++) begin
      @(negedge clk);
      meas_in = pat(4, p);
    end
    @(negedge clk);
    meas_in = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst count_out", count_out, 0);
    chk("arst count_valid", count_valid, 0);
    chk("arst in_range", in_range, 0);
    chk("arst locked", locked, 0);
    repeat (3) @(negedge clk);
    run_window(4, 2, 24, 25, 1, 0);
    @(negedge clk);
    enable = 1'b0;

    // 6b: 499 edges in a 1000-cycle window saturate an 8-bit count
    for (int p = 0; p < 1000; p++) begin
      @(negedge clk);
      if (p == 0) begin
        enable2 = 1'b1;
        e2.lo = 255; e2.hi = 255; e2.ir = 1'b0; e2.lk = 1'b0;
        e2.t  = longint'($time) + 1000 * PER;
        q2.push_back(e2);
      end
      meas2 = pat(2, p);
    end

    repeat (20) @(negedge clk);
    chk("pending_windows", q.size(), 0);
    chk("pending_windows_sat", q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
